serial_transmitter: RTL and testbench

//  Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake
//  and shifts it out one bit per clk, MSB- or LSB-first. It is the sending end of the serial

---
 rtl/serial_pkg.sv | 16 +
 rtl/serial_bit_counter.sv | 29 ++
 rtl/serial_transmitter.sv | 125 ++++++++++++
 tb/tb_serial_transmitter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the serial transmitter: FSM state encodings and bit-order constants.
// SERIAL_TRANSMITTER_PARITY_EN adds the PARITY state used by the optional even-parity bit.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1
`ifdef SERIAL_TRANSMITTER_PARITY_EN
      ,PARITY = 2'd2
`endif
   } tx_state_t;

   localparam logic MSB_FIRST = 1'b1;
   localparam logic LSB_FIRST = 1'b0;

endpackage

// File: rtl/serial_bit_counter.sv
// Data-bit index counter for the serial transmitter: clear wins over enable,
// counts 0..WIDTH-1 and holds at the terminal value instead of wrapping.
module serial_bit_counter #(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          sync_reset,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] count,
   output logic          terminal
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   assign terminal = (count == LAST);

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !terminal) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/serial_transmitter.sv
// Parallel-in/serial-out transmitter with valid/ready word intake and gapless back-to-back frames.
// Build option SERIAL_TRANSMITTER_PARITY_EN appends one even-parity bit to every frame.
module serial_transmitter
   import serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             sync_reset,
   input  logic [WIDTH-1:0] parallel_data_input,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             msb_first,
   output logic             serial_data_output,
   output logic             serial_valid,
   output logic             frame_done,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

   tx_state_t        state;
   logic [WIDTH-1:0] shreg;
   logic             msb_r;
   logic [CW-1:0]    cnt;
   logic             tc;
   logic             last_bit;
   logic             accept;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
   logic             par_r;
`endif

   // Handshake: a word transfers on any rising edge where load_valid && load_ready.
   // load_ready depends only on state/count (and reset), never on load_valid.
`ifdef SERIAL_TRANSMITTER_PARITY_EN
   assign last_bit = (state == PARITY);
`else
   assign last_bit = (state == SHIFT) && tc;
`endif
   assign load_ready = !sync_reset && ((state == IDLE) || last_bit);
   assign accept     = load_valid && load_ready;
   assign state_dbg  = state;

   serial_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk        (clk),
      .sync_reset (sync_reset),
      .clear      (accept),
      .enable     (state == SHIFT),
      .count      (cnt),
      .terminal   (tc)
   );

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state              <= IDLE;
         shreg              <= '0;
         msb_r              <= 1'b0;
         serial_data_output <= 1'b0;
         serial_valid       <= 1'b0;
         frame_done         <= 1'b0;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
         par_r              <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         if (accept) begin
            // First bit goes straight to the output; the shift reg keeps the rest.
            state        <= SHIFT;
            msb_r        <= msb_first;
            serial_valid <= 1'b1;
            if (msb_first == MSB_FIRST) begin
               serial_data_output <= parallel_data_input[WIDTH-1];
               shreg              <= {parallel_data_input[WIDTH-2:0], 1'b0};
            end else begin
               serial_data_output <= parallel_data_input[0];
               shreg              <= {1'b0, parallel_data_input[WIDTH-1:1]};
            end
`ifdef SERIAL_TRANSMITTER_PARITY_EN
            par_r <= ^parallel_data_input;
`endif
         end else begin
            case (state)
               SHIFT: begin
                  if (tc) begin
`ifdef SERIAL_TRANSMITTER_PARITY_EN
                     state              <= PARITY;
                     serial_data_output <= par_r;
                     frame_done         <= 1'b1;
`else
                     state              <= IDLE;
                     serial_valid       <= 1'b0;
                     serial_data_output <= 1'b0;
`endif
                  end else begin
                     if (msb_r == MSB_FIRST) begin
                        serial_data_output <= shreg[WIDTH-1];
                        shreg              <= {shreg[WIDTH-2:0], 1'b0};
                     end else begin
                        serial_data_output <= shreg[0];
                        shreg              <= {1'b0, shreg[WIDTH-1:1]};
                     end
`ifndef SERIAL_TRANSMITTER_PARITY_EN
                     frame_done <= (cnt == PENULT);
`endif
                  end
               end
`ifdef SERIAL_TRANSMITTER_PARITY_EN
               PARITY: begin
                  state              <= IDLE;
                  serial_valid       <= 1'b0;
                  serial_data_output <= 1'b0;
               end
`endif
               default: begin
                  state              <= IDLE;
                  serial_valid       <= 1'b0;
                  serial_data_output <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: directed scenarios then random traffic, checked every cycle
// against a queue of frame bits still owed on the serial line.
module tb_serial_transmitter;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         sync_reset;
   logic [W-1:0] parallel_data_input;
   logic         load_valid;
   logic         load_ready;
   logic         msb_first;
   logic         serial_data_output;
   logic         serial_valid;
   logic         frame_done;
   logic [1:0]   state_dbg;

   int vectors = 0;
   int miscompares = 0;
   logic chk_en = 1'b0;

   // Bits the line still has to present, head = bit on the output this cycle.
   logic exp_q[$];

   always #5 clk = ~clk;

   serial_transmitter #(.WIDTH(W)) dut (
      .clk                 (clk),
      .sync_reset          (sync_reset),
      .parallel_data_input (parallel_data_input),
      .load_valid          (load_valid),
      .load_ready          (load_ready),
      .msb_first           (msb_first),
      .serial_data_output  (serial_data_output),
      .serial_valid        (serial_valid),
      .frame_done          (frame_done),
      .state_dbg           (state_dbg)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [W-1:0] d, input logic m);
      for (int i = 0; i < W; i++)
         exp_q.push_back(m ? d[W-1-i] : d[i]);
`ifdef SERIAL_TRANSMITTER_PARITY_EN
      exp_q.push_back(^d);
`endif
   endtask

   // Drive one cycle's inputs at the falling edge, check, then advance the model at the rising edge.
   task automatic step(input logic v, input logic [W-1:0] d, input logic m, input logic r);
      logic acc;
      load_valid = v;
      parallel_data_input = d;
      msb_first = m;
      sync_reset = r;
      #1;
      if (chk_en) begin
         check("load_ready", load_ready, !r && (exp_q.size() <= 1));
         check("serial_valid", serial_valid, exp_q.size() > 0);
         check("serial_data", serial_data_output, (exp_q.size() > 0) ? exp_q[0] : 1'b0);
         check("frame_done", frame_done, exp_q.size() == 1);
         check("state_idle", state_dbg == 2'd0, exp_q.size() == 0);
      end
      acc = v && !r && (exp_q.size() <= 1);
      @(posedge clk);
      if (r) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         if (acc) push_frame(d, m);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, W'($urandom), 1'($urandom), 1'b0);
   endtask

   initial begin
      load_valid = 1'b0;
      parallel_data_input = '0;
      msb_first = 1'b0;
      sync_reset = 1'b1;
      @(negedge clk);
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 8'hFF, 1'b1, 1'b1);
      chk_en = 1'b1;
      // Reset state, load_ready held low while reset is asserted.
      step(1'b1, 8'hFF, 1'b1, 1'b1);
      idle(2);

      // MSB-first 8'hF0, then LSB-first 8'b1011_0001 with valid dropping afterwards.
      step(1'b1, 8'hF0, 1'b1, 1'b0);
      idle(10);
      step(1'b1, 8'b1011_0001, 1'b0, 1'b0);
      idle(10);

      // Back-to-back: second word held valid until taken on the final-bit cycle.
      step(1'b1, 8'hA5, 1'b1, 1'b0);
      for (int i = 0; i < 12 && exp_q.size() != 1; i++)
         step(1'b1, 8'h3C, 1'b1, 1'b0);
      step(1'b1, 8'h3C, 1'b1, 1'b0);
      idle(11);

      // Offer 8'hFF on the 3rd bit of an all-zero frame: must be dropped.
      step(1'b1, 8'h00, 1'b0, 1'b0);
      idle(2);
      step(1'b1, 8'hFF, 1'b1, 1'b0);
      idle(10);

      // Reset on the 4th bit of 8'hF0 aborts the frame.
      step(1'b1, 8'hF0, 1'b1, 1'b0);
      idle(3);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      idle(3);

      // Parity corner words (plain frames when the option is off).
      step(1'b1, 8'hF0, 1'b1, 1'b0);
      idle(10);
      step(1'b1, 8'h01, 1'b0, 1'b0);
      idle(10);

      // Random traffic with mid-frame input churn and occasional resets.
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom),
              $urandom_range(0, 59) == 0);
      idle(12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
